// File: rtl/logs_pkg.sv
// logs_pkg: shared defaults and command type for the logs_nco scheduler slice
package logs_pkg;
  localparam int LOGS_N = 5;
  localparam int LOGS_V = 4;
  localparam int LOGS_DIV = 16;
  localparam int LOGS_D = 8;
  function automatic int clog2_min1(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction
  typedef struct packed {
    logic [$clog2(LOGS_V)-1:0] voice;
    logic [LOGS_N-2:0] freq;
    logic [LOGS_D-1:0] dur;
  } cmd_t;
endpackage

// File: rtl/logs_step_prescaler.sv
// logs_step_prescaler: free-running 0..DIV-1 counter with a registered one-cycle step strobe
module logs_step_prescaler
  import logs_pkg::*;
#(
  parameter int DIV = LOGS_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);
  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] count;
  // wrap the count at DIV-1 and strobe step the cycle after the count reaches it
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= '0;
      step <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CW'(1);
      step <= (count == LAST);
    end
endmodule

// File: rtl/logs_nco_sched.sv
// logs_nco_sched: step tick generator and step-aligned frequency scheduler; LOGS_SCHED_DUR_EN builds note duration counters
module logs_nco_sched
  import logs_pkg::*;
#(
  parameter int N = LOGS_N,
  parameter int V = LOGS_V,
  parameter int DIV = LOGS_DIV,
  parameter int D = LOGS_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [clog2_min1(V)-1:0] cmd_voice,
  input  logic [N-2:0]            cmd_freq,
  input  logic [D-1:0]            cmd_dur,
  output logic                    step,
  output logic [V*(N-1)-1:0]      freq_out,
  output logic [V-1:0]            active
);
  localparam int VW = clog2_min1(V);
  localparam int FW = N - 1;
  logic full;
  logic accept;
  logic apply;
  logic [VW-1:0] s_voice;
  logic [FW-1:0] s_freq;
  logs_step_prescaler #(.DIV(DIV)) u_pre (.clk(clk), .rst_n(rst_n), .step(step));
  assign cmd_ready = !full;
  assign accept = cmd_valid && !full;
  assign apply = step && full;
`ifdef LOGS_SCHED_DUR_EN
  logic [D-1:0] s_dur;
  // one-deep pending slot: fill on handshake, drain on the step edge
  always_ff @(posedge clk)
    if (!rst_n) full <= 1'b0;
    else if (accept) begin
      full <= 1'b1;
      s_voice <= cmd_voice;
      s_freq <= cmd_freq;
      s_dur <= cmd_dur;
    end else if (apply) full <= 1'b0;
`else
  logic unused_dur;
  assign unused_dur = ^cmd_dur;
  // one-deep pending slot: fill on handshake, drain on the step edge
  always_ff @(posedge clk)
    if (!rst_n) full <= 1'b0;
    else if (accept) begin
      full <= 1'b1;
      s_voice <= cmd_voice;
      s_freq <= cmd_freq;
    end else if (apply) full <= 1'b0;
`endif
  for (genvar v = 0; v < V; v++) begin : g_voice
    logic [FW-1:0] f_q;
    logic a_q;
    logic hit;
    assign hit = apply && (s_voice == VW'(v));
`ifdef LOGS_SCHED_DUR_EN
    logic [D-1:0] cnt_q;
    logic sus_q;
    logic dec;
    assign dec = step && a_q && !sus_q && (cnt_q != '0);
    // apply takes priority over expiry; timed notes count down one per step and silence at 1->0
    always_ff @(posedge clk)
      if (!rst_n) begin
        f_q <= '0;
        a_q <= 1'b0;
        cnt_q <= '0;
        sus_q <= 1'b0;
      end else if (hit) begin
        f_q <= s_freq;
        a_q <= (s_freq != '0);
        cnt_q <= s_dur;
        sus_q <= (s_dur == '0);
      end else if (dec) begin
        cnt_q <= cnt_q - D'(1);
        if (cnt_q == D'(1)) begin
          f_q <= '0;
          a_q <= 1'b0;
        end
      end
`else
    // every note sustains until overwritten
    always_ff @(posedge clk)
      if (!rst_n) begin
        f_q <= '0;
        a_q <= 1'b0;
      end else if (hit) begin
        f_q <= s_freq;
        a_q <= (s_freq != '0);
      end
`endif
    assign freq_out[v*FW +: FW] = f_q;
    assign active[v] = a_q;
  end
endmodule
